// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result channels and CDB broadcast bundle for cdb_arbiter
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif
interface cdb_arbiter_if #(
   parameter int NUM_FU = 2,
   parameter int VAL_W  = `GPR_SIZE,
   parameter int IDX_W  = `ROB_IDX_SIZE
);
   logic [NUM_FU-1:0]       in_fu_done;
   logic [NUM_FU*IDX_W-1:0] in_fu_dst_rob_index;
   logic [NUM_FU*VAL_W-1:0] in_fu_value;
   logic [NUM_FU-1:0]       in_fu_set_nzcv;
   logic [NUM_FU*4-1:0]     in_fu_nzcv;
   logic                    in_rob_is_mispred;
   logic [NUM_FU-1:0]       out_fu_ready;
   logic                    out_rob_done;
   logic [IDX_W-1:0]        out_rob_dst_rob_index;
   logic [VAL_W-1:0]        out_rob_value;
   logic                    out_rob_set_nzcv;
   logic [3:0]              out_rob_nzcv;
   logic                    out_overflow;
   modport master (
      output in_fu_done, in_fu_dst_rob_index, in_fu_value, in_fu_set_nzcv, in_fu_nzcv, in_rob_is_mispred,
      input  out_fu_ready, out_rob_done, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv, out_overflow
   );
   modport slave (
      input  in_fu_done, in_fu_dst_rob_index, in_fu_value, in_fu_set_nzcv, in_fu_nzcv, in_rob_is_mispred,
      output out_fu_ready, out_rob_done, out_rob_dst_rob_index, out_rob_value, out_rob_set_nzcv, out_rob_nzcv, out_overflow
   );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result FIFOs round-robin arbitrated onto one CDB broadcast; optional flush via CDB_FLUSH_EN
`ifndef GPR_SIZE
`define GPR_SIZE 64
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 6
`endif
module cdb_arbiter #(
   parameter int NUM_FU = 2,
   parameter int DEPTH  = 4,
   parameter int VAL_W  = `GPR_SIZE,
   parameter int IDX_W  = `ROB_IDX_SIZE
) (
   input logic          in_clk,
   input logic          in_rst,
   cdb_arbiter_if.slave bus
);
   localparam int PW = $clog2(NUM_FU);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = IDX_W + VAL_W + 5;
   logic [NUM_FU-1:0] rdy, ne, push, pop;
   logic [EW-1:0]     hd [NUM_FU];
   logic [PW-1:0]     rr, gnt;
   logic              gv, clr, drop;
`ifdef CDB_FLUSH_EN
   assign clr = bus.in_rob_is_mispred;
`else
   assign clr = 1'b0;
`endif
   assign bus.out_fu_ready = rdy;
   assign drop = |(bus.in_fu_done & ~rdy);
   for (genvar g = 0; g < NUM_FU; g++) begin : ch
      logic [EW-1:0] q [DEPTH];
      logic [AW-1:0] hp, tp;
      logic [CW-1:0] cnt;
      assign rdy[g]  = cnt != CW'(DEPTH);
      assign ne[g]   = cnt != '0;
      assign push[g] = bus.in_fu_done[g] & rdy[g];
      assign pop[g]  = gv & (gnt == PW'(g));
      assign hd[g]   = q[hp];
      // channel FIFO: write tail on accepted push, advance head on grant
      always_ff @(posedge in_clk) begin
         if (in_rst || clr) begin
            hp  <= '0;
            tp  <= '0;
            cnt <= '0;
         end else begin
            if (push[g]) begin
               q[tp] <= {bus.in_fu_dst_rob_index[g*IDX_W +: IDX_W], bus.in_fu_value[g*VAL_W +: VAL_W],
                         bus.in_fu_set_nzcv[g], bus.in_fu_nzcv[g*4 +: 4]};
               tp    <= tp + 1'b1;
            end
            if (pop[g]) hp <= hp + 1'b1;
            cnt <= cnt + CW'(push[g]) - CW'(pop[g]);
         end
      end
   end
   // round-robin pick: lowest non-empty channel at or above rr, else wrap to lowest non-empty
   always_comb begin
      gv  = |ne;
      gnt = '0;
      for (int i = NUM_FU - 1; i >= 0; i--) if (ne[i]) gnt = PW'(i);
      for (int i = NUM_FU - 1; i >= 0; i--) if (ne[i] && PW'(i) >= rr) gnt = PW'(i);
   end
   // round-robin pointer moves just past the last granted channel
   always_ff @(posedge in_clk) begin
      if (in_rst || clr) rr <= '0;
      else if (gv) rr <= (gnt == PW'(NUM_FU - 1)) ? '0 : gnt + 1'b1;
   end
   // broadcast register: load granted head entry, hold fields while idle
   always_ff @(posedge in_clk) begin
      if (in_rst) begin
         bus.out_rob_done <= 1'b0;
         {bus.out_rob_dst_rob_index, bus.out_rob_value, bus.out_rob_set_nzcv, bus.out_rob_nzcv} <= '0;
      end else begin
         bus.out_rob_done <= gv & ~clr;
         if (gv && !clr) {bus.out_rob_dst_rob_index, bus.out_rob_value, bus.out_rob_set_nzcv, bus.out_rob_nzcv} <= hd[gnt];
      end
   end
   // sticky flag for any push offered to a full channel
   always_ff @(posedge in_clk) begin
      if (in_rst) bus.out_overflow <= 1'b0;
      else if (drop) bus.out_overflow <= 1'b1;
   end
endmodule
